// File: rtl/otbn_pq_pkg.sv
// Shared types and helpers for the PQ write-back lane merger.
package otbn_pq_pkg;

   localparam int PQLEN  = 32;
   localparam int NLANES = 8;
   localparam int WDR_AW = 5;
   localparam int WLEN   = PQLEN * NLANES;

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      PENDING
   } wb_buf_state_e;

   typedef struct packed {
      wb_buf_state_e     state;
      logic [WDR_AW-1:0] addr;
      logic [WLEN-1:0]   data;
      logic [NLANES-1:0] mask;
   } wb_buf_t;

   // A buffer can take a lane for addr a without first being written back.
   function automatic logic buf_fits(wb_buf_t b, logic [WDR_AW-1:0] a);
      return (b.state == EMPTY) || (b.state == FILLING && b.addr == a);
   endfunction

   function automatic logic buf_holds(wb_buf_t b, logic [WDR_AW-1:0] a);
      return (b.state != EMPTY) && (b.addr == a);
   endfunction

endpackage

// File: rtl/otbn_pq_wb_buf.sv
// One write-back buffer: state register, lane insert and close logic.
module otbn_pq_wb_buf
   import otbn_pq_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      wr_a,
   input  logic [$clog2(NLANES)-1:0] lane_a,
   input  logic [PQLEN-1:0]          data_a,
   input  logic                      wr_b,
   input  logic [$clog2(NLANES)-1:0] lane_b,
   input  logic [PQLEN-1:0]          data_b,
   input  logic [WDR_AW-1:0]         addr,
   input  logic                      close,
   input  logic                      drain,
   output wb_buf_t                   buf_q
);

   wb_buf_t buf_d;

   always_comb begin
      // NOTE: default-first assignment keeps this always_comb latch-free.
      buf_d = buf_q;
      if (drain) begin
         buf_d.state = EMPTY;
         buf_d.mask  = '0;
      end else if (buf_q.state != PENDING) begin
         if (wr_a || wr_b) begin
            if (buf_q.state == EMPTY) buf_d.addr = addr;
            buf_d.state = FILLING;
         end
         if (wr_a) begin
            buf_d.data[int'(lane_a)*PQLEN +: PQLEN] = data_a;
            buf_d.mask[lane_a] = 1'b1;
         end
         // Port b is applied last so it wins a same-lane collision.
         if (wr_b) begin
            buf_d.data[int'(lane_b)*PQLEN +: PQLEN] = data_b;
            buf_d.mask[lane_b] = 1'b1;
         end
         if (buf_d.state == FILLING && (close || (&buf_d.mask))) buf_d.state = PENDING;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: data is reset too, so wr_data_o reads zero straight out of reset.
         buf_q <= '{state: EMPTY, addr: '0, data: '0, mask: '0};
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments only.
         buf_q <= buf_d;
      end
   end

endmodule

// File: rtl/otbn_pq_wb_merge.sv
// Write-back lane merger: packs per-lane PQ ALU results into masked 256-bit WDR writes.
module otbn_pq_wb_merge #(
   parameter int PQLEN  = 32,
   parameter int NLANES = 8,
   parameter int WDR_AW = 5
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [1:0]                in_we_i,
   input  logic [WDR_AW-1:0]         in_wdr0_i,
   input  logic [WDR_AW-1:0]         in_wdr1_i,
   input  logic [$clog2(NLANES)-1:0] in_lane0_i,
   input  logic [$clog2(NLANES)-1:0] in_lane1_i,
   input  logic [PQLEN-1:0]          in_data0_i,
   input  logic [PQLEN-1:0]          in_data1_i,
   input  logic                      in_last_i,
   input  logic                      flush_i,
   output logic                      wr_valid_o,
   input  logic                      wr_ready_i,
   output logic [WDR_AW-1:0]         wr_addr_o,
   output logic [PQLEN*NLANES-1:0]   wr_data_o,
   output logic [NLANES-1:0]         wr_lane_en_o,
   output logic                      idle_o
);
   import otbn_pq_pkg::*;

   wb_buf_t b0, b1;
   logic    merge, b0_en, b1_en, b0_block, b1_block, haz_b0, haz_b1;
   logic    accept, stall, close0, close1, sel_b0, drain0, drain1;

   // Both channels to the same WDR share B0 so one write covers both lanes.
   assign merge    = in_we_i[0] & in_we_i[1] & (in_wdr0_i == in_wdr1_i);
   assign b0_en    = in_we_i[0];
   assign b1_en    = in_we_i[1] & ~merge;
   assign b0_block = b0_en & ~buf_fits(b0, in_wdr0_i);
   assign b1_block = b1_en & ~buf_fits(b1, in_wdr1_i);
   // haz_bK: buffer K already owns the WDR the other buffer is about to open.
   assign haz_b0   = b1_en & buf_holds(b0, in_wdr1_i);
   assign haz_b1   = b0_en & buf_holds(b1, in_wdr0_i);

   assign in_ready_o = ~flush_i & ~(b0_block | b1_block | haz_b0 | haz_b1);
   assign accept     = in_valid_i & in_ready_o;
   assign stall      = in_valid_i & ~in_ready_o;
   assign close0     = flush_i | (stall & (b0_block | haz_b0)) | (accept & in_last_i);
   assign close1     = flush_i | (stall & (b1_block | haz_b1)) | (accept & in_last_i);

   assign sel_b0 = (b0.state == PENDING);
   assign drain0 = sel_b0 & wr_ready_i;
   assign drain1 = ~sel_b0 & (b1.state == PENDING) & wr_ready_i;

   otbn_pq_wb_buf u_buf0 (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .wr_a   (accept & in_we_i[0]),
      .lane_a (in_lane0_i),
      .data_a (in_data0_i),
      .wr_b   (accept & merge),
      .lane_b (in_lane1_i),
      .data_b (in_data1_i),
      .addr   (in_wdr0_i),
      .close  (close0),
      .drain  (drain0),
      .buf_q  (b0)
   );

   otbn_pq_wb_buf u_buf1 (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .wr_a   (accept & b1_en),
      .lane_a (in_lane1_i),
      .data_a (in_data1_i),
      .wr_b   (1'b0),
      .lane_b ('0),
      .data_b ('0),
      .addr   (in_wdr1_i),
      .close  (close1),
      .drain  (drain1),
      .buf_q  (b1)
   );

   always_comb begin
      wr_valid_o   = 1'b0;
      wr_addr_o    = '0;
      wr_data_o    = '0;
      wr_lane_en_o = '0;
      if (sel_b0) begin
         wr_valid_o   = 1'b1;
         wr_addr_o    = b0.addr;
         wr_data_o    = b0.data;
         wr_lane_en_o = b0.mask;
      end else if (b1.state == PENDING) begin
         wr_valid_o   = 1'b1;
         wr_addr_o    = b1.addr;
         wr_data_o    = b1.data;
         wr_lane_en_o = b1.mask;
      end
   end

   assign idle_o = (b0.state == EMPTY) && (b1.state == EMPTY);

endmodule

// File: tb/tb_otbn_pq_wb_merge.sv
// Directed and randomized bench for otbn_pq_wb_merge with a transaction-level write model.
module tb_otbn_pq_wb_merge;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         in_valid_i, in_ready_o, in_last_i, flush_i;
   logic [1:0]   in_we_i;
   logic [4:0]   in_wdr0_i, in_wdr1_i;
   logic [2:0]   in_lane0_i, in_lane1_i;
   logic [31:0]  in_data0_i, in_data1_i;
   logic         wr_valid_o, wr_ready_i, idle_o;
   logic [4:0]   wr_addr_o;
   logic [255:0] wr_data_o;
   logic [7:0]   wr_lane_en_o;

   always #5 clk_i = ~clk_i;

   otbn_pq_wb_merge dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .in_we_i      (in_we_i),
      .in_wdr0_i    (in_wdr0_i),
      .in_wdr1_i    (in_wdr1_i),
      .in_lane0_i   (in_lane0_i),
      .in_lane1_i   (in_lane1_i),
      .in_data0_i   (in_data0_i),
      .in_data1_i   (in_data1_i),
      .in_last_i    (in_last_i),
      .flush_i      (flush_i),
      .wr_valid_o   (wr_valid_o),
      .wr_ready_i   (wr_ready_i),
      .wr_addr_o    (wr_addr_o),
      .wr_data_o    (wr_data_o),
      .wr_lane_en_o (wr_lane_en_o),
      .idle_o       (idle_o)
   );

   typedef struct {
      logic [4:0]   addr;
      logic [255:0] data;
      logic [7:0]   en;
   } wr_t;

   wr_t obs_q[$];
   wr_t exp_q[2][$];
   int  n_cmp = 0;
   int  n_err = 0;

   // Reference model: one open write group per channel pool.
   logic         g_open[2];
   logic [4:0]   g_addr[2];
   logic [255:0] g_data[2];
   logic [7:0]   g_mask[2];

   always @(negedge clk_i)
      if (rst_ni && wr_valid_o && wr_ready_i)
         obs_q.push_back('{addr: wr_addr_o, data: wr_data_o, en: wr_lane_en_o});

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] lane_bits(input logic [7:0] en);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = {32{en[i]}};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid_i = 1'b0; in_we_i = 2'b00; in_last_i = 1'b0; flush_i = 1'b0;
      in_wdr0_i = '0; in_wdr1_i = '0; in_lane0_i = '0; in_lane1_i = '0;
      in_data0_i = '0; in_data1_i = '0;
   endtask

   // Present one beat and hold it until accepted; returns the number of stalled cycles.
   task automatic send(input logic [1:0] we, input logic [4:0] a0, input logic [2:0] l0,
                       input logic [31:0] d0, input logic [4:0] a1, input logic [2:0] l1,
                       input logic [31:0] d1, input logic last, input bit rnd_rdy,
                       output int stalls);
      bit done;
      done = 1'b0;
      stalls = 0;
      in_valid_i = 1'b1; in_we_i = we; in_last_i = last;
      in_wdr0_i = a0; in_lane0_i = l0; in_data0_i = d0;
      in_wdr1_i = a1; in_lane1_i = l1; in_data1_i = d1;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk_i);
         if (in_ready_o) done = 1'b1;
         else stalls++;
         tick();
         if (rnd_rdy) wr_ready_i = 1'($urandom_range(0, 1));
      end
      check("beat_accepted", done, 1);
      idle_inputs();
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk_i);
         if (idle_o) done = 1'b1;
         tick();
      end
      check(tag, done, 1);
   endtask

   task automatic flush_and_drain(input string tag);
      wr_ready_i = 1'b1;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      wait_idle(tag);
   endtask

   task automatic check_write(input string tag, input int idx, input logic [4:0] addr,
                              input logic [7:0] en, input logic [255:0] data);
      check({tag, "_present"}, obs_q.size() > idx, 1);
      if (obs_q.size() > idx) begin
         check({tag, "_addr"}, obs_q[idx].addr, addr);
         check({tag, "_en"}, obs_q[idx].en, en);
         check({tag, "_data"}, obs_q[idx].data & lane_bits(en), data & lane_bits(en));
      end
   endtask

   task automatic model_close(input int p);
      if (g_open[p]) exp_q[p].push_back('{addr: g_addr[p], data: g_data[p], en: g_mask[p]});
      g_open[p] = 1'b0;
   endtask

   task automatic model_add(input int p, input logic [4:0] a, input logic [2:0] l, input logic [31:0] d);
      if (g_open[p] && g_addr[p] != a) model_close(p);
      if (!g_open[p]) begin
         g_open[p] = 1'b1; g_addr[p] = a; g_mask[p] = '0; g_data[p] = '0;
      end
      g_data[p][int'(l)*32 +: 32] = d;
      g_mask[p][l] = 1'b1;
      if (&g_mask[p]) model_close(p);
   endtask

   initial begin
      int           st, tot;
      logic [255:0] exp_d;
      logic [31:0]  dx, dy;
      int           cur0, cur1;

      // Reset state
      idle_inputs();
      wr_ready_i = 1'b0;
      rst_ni = 1'b0;
      repeat (2) tick();
      check("rst_idle", idle_o, 1);
      check("rst_wr_valid", wr_valid_o, 0);
      check("rst_in_ready", in_ready_o, 1);
      check("rst_wr_addr", wr_addr_o, 0);
      check("rst_wr_data", wr_data_o, 0);
      check("rst_lane_en", wr_lane_en_o, 0);
      rst_ni = 1'b1;
      tick();

      // Full 8-lane sweep to WDR 3
      wr_ready_i = 1'b1;
      obs_q.delete();
      tot = 0;
      exp_d = '0;
      for (int i = 0; i < 8; i++) begin
         send(2'b01, 5'd3, 3'(i), 32'h100 + 32'(i), 5'd0, 3'd0, 32'h0, 1'b0, 1'b0, st);
         tot += st;
         exp_d[i*32 +: 32] = 32'h100 + 32'(i);
      end
      check("sweep_no_stall", tot, 0);
      check("sweep_valid_next", wr_valid_o, 1);
      check("sweep_addr", wr_addr_o, 3);
      check("sweep_en", wr_lane_en_o, 8'hFF);
      check("sweep_data", wr_data_o, exp_d);
      send(2'b01, 5'd3, 3'd0, 32'h200, 5'd0, 3'd0, 32'h0, 1'b0, 1'b0, st);
      check("sweep_refill_stall", st, 1);
      check("sweep_one_write", obs_q.size(), 1);
      flush_and_drain("sweep_cleanup");
      obs_q.delete();

      // Address change closes the open buffer
      send(2'b01, 5'd4, 3'd0, 32'h40, 5'd0, 3'd0, 32'h0, 1'b0, 1'b0, st);
      send(2'b01, 5'd4, 3'd1, 32'h41, 5'd0, 3'd0, 32'h0, 1'b0, 1'b0, st);
      send(2'b01, 5'd5, 3'd2, 32'h52, 5'd0, 3'd0, 32'h0, 1'b0, 1'b0, st);
      check("addr_change_stalled", st > 0, 1);
      check("addr_change_writes", obs_q.size(), 1);
      check_write("addr_change_w0", 0, 5'd4, 8'h03, {192'h0, 32'h41, 32'h40});
      flush_and_drain("addr_change_cleanup");
      check_write("addr_change_w1", 1, 5'd5, 8'h04, {160'h0, 32'h52, 64'h0});
      obs_q.delete();

      // Both channels, same WDR and lane: channel 1 wins
      send(2'b11, 5'd7, 3'd2, 32'hAAAA, 5'd7, 3'd2, 32'h5555, 1'b1, 1'b0, st);
      check("merge_no_stall", st, 0);
      check("merge_valid_next", wr_valid_o, 1);
      wait_idle("merge_drain");
      check("merge_writes", obs_q.size(), 1);
      check_write("merge_w0", 0, 5'd7, 8'h04, {160'h0, 32'h5555, 64'h0});
      obs_q.delete();

      // Backpressure with both buffers pending
      wr_ready_i = 1'b0;
      dx = $urandom;
      dy = $urandom;
      send(2'b11, 5'd10, 3'd1, dx, 5'd11, 3'd6, dy, 1'b1, 1'b0, st);
      for (int c = 0; c < 5; c++) begin
         check("hold_valid", wr_valid_o, 1);
         check("hold_addr", wr_addr_o, 10);
         check("hold_en", wr_lane_en_o, 8'h02);
         check("hold_lane1", wr_data_o[63:32], dx);
         tick();
      end
      wr_ready_i = 1'b1;
      tick();
      check("hold_b1_valid", wr_valid_o, 1);
      check("hold_b1_addr", wr_addr_o, 11);
      tick();
      check("hold_idle", idle_o, 1);
      check("hold_writes", obs_q.size(), 2);
      check_write("hold_w0", 0, 5'd10, 8'h02, {192'h0, dx, 32'h0});
      check_write("hold_w1", 1, 5'd11, 8'h40, {32'h0, dy, 192'h0});
      obs_q.delete();

      // Flush followed by reset discards the pending write
      send(2'b10, 5'd0, 3'd0, 32'h0, 5'd9, 3'd4, 32'h94, 1'b0, 1'b0, st);
      send(2'b10, 5'd0, 3'd0, 32'h0, 5'd9, 3'd5, 32'h95, 1'b0, 1'b0, st);
      flush_i = 1'b1;
      @(negedge clk_i);
      check("flush_blocks_ready", in_ready_o, 0);
      tick();
      flush_i = 1'b0;
      rst_ni = 1'b0;
      #2;
      check("flush_rst_valid", wr_valid_o, 0);
      check("flush_rst_idle", idle_o, 1);
      tick();
      rst_ni = 1'b1;
      repeat (3) tick();
      check("flush_rst_no_write", obs_q.size(), 0);
      check("flush_rst_idle_after", idle_o, 1);
      check("flush_rst_data", wr_data_o, 0);

      // Randomized traffic: ch0 uses WDR 0..3, ch1 uses WDR 16..19
      obs_q.delete();
      for (int p = 0; p < 2; p++) begin
         g_open[p] = 1'b0; g_addr[p] = '0; g_data[p] = '0; g_mask[p] = '0;
      end
      cur0 = 0;
      cur1 = 16;
      for (int n = 0; n < 300; n++) begin
         int r;
         r = int'($urandom_range(0, 19));
         if (r == 0) begin
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
            model_close(0);
            model_close(1);
         end else if (r == 1) begin
            tick();
         end else begin
            logic [1:0]  we;
            logic [2:0]  l0, l1;
            logic [31:0] d0, d1;
            logic        last;
            we   = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) cur0 = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) cur1 = int'($urandom_range(16, 19));
            l0   = 3'($urandom_range(0, 7));
            l1   = 3'($urandom_range(0, 7));
            d0   = $urandom;
            d1   = $urandom;
            last = ($urandom_range(0, 9) == 0);
            send(we, 5'(cur0), l0, d0, 5'(cur1), l1, d1, last, 1'b1, st);
            if (we[0]) model_add(0, 5'(cur0), l0, d0);
            if (we[1]) model_add(1, 5'(cur1), l1, d1);
            if (last) begin
               model_close(0);
               model_close(1);
            end
         end
         wr_ready_i = 1'($urandom_range(0, 1));
      end
      model_close(0);
      model_close(1);
      flush_and_drain("rand_final_drain");
      check("rand_write_count", obs_q.size(), exp_q[0].size() + exp_q[1].size());
      foreach (obs_q[i]) begin
         int  p;
         wr_t e;
         p = int'(obs_q[i].addr[4]);
         check("rand_expected_left", exp_q[p].size() > 0, 1);
         if (exp_q[p].size() > 0) begin
            e = exp_q[p].pop_front();
            check("rand_addr", obs_q[i].addr, e.addr);
            check("rand_en", obs_q[i].en, e.en);
            check("rand_data", obs_q[i].data & lane_bits(e.en), e.data & lane_bits(e.en));
         end
      end
      check("rand_q0_empty", exp_q[0].size(), 0);
      check("rand_q1_empty", exp_q[1].size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
